// File: rtl/powerline_event_sequencer_pkg.sv
// Shared definitions for the power-line event sequencer: FSM state encoding
// and default widths used by the top and its period-meter sub-module.
package powerline_event_sequencer_pkg;

    localparam int unsigned DEF_PERIOD_WIDTH  = 24;
    localparam int unsigned DEF_DELAY_WIDTH   = 24;
    localparam int unsigned DEF_DIVISOR_WIDTH = 8;
    localparam int unsigned DEF_OVERRUN_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DELAY = 1'b1
    } pes_state_e;

endpackage

// File: rtl/powerline_event_sequencer_period.sv
// Period meter: detects the rising edge of the stretched line trigger and
// measures the number of clk ticks between consecutive rises. The running
// counter saturates, so an absent line reads back as all-ones.
module powerline_period_meter
    import powerline_event_sequencer_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trigger,
    output logic                    rise,
    output logic [PERIOD_WIDTH-1:0] periodTicks,
    output logic                    periodValid
);

    localparam logic [PERIOD_WIDTH-1:0] CNT_ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_WIDTH-1:0] CNT_ZERO = {PERIOD_WIDTH{1'b0}};
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX  = {PERIOD_WIDTH{1'b1}};

    logic                    trigger_d_r;
    logic [PERIOD_WIDTH-1:0] count_r;
    logic [PERIOD_WIDTH-1:0] ticks_r;
    logic                    valid_r;
    logic                    seen_first_r;
    logic                    rise_s;

    // One rise per stretched pulse: current level high, previous level low.
    always_comb begin
        rise_s = trigger & ~trigger_d_r;
    end

    // Delayed trigger copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger_d_r <= 1'b0;
        end else begin
            trigger_d_r <= trigger;
        end
    end

    // Free-running saturating tick counter, restarted at 1 on every rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else if (rise_s) begin
            count_r <= CNT_ONE;
        end else if (count_r != CNT_MAX) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // Latch the measured period; valid once two rises bracket a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ticks_r      <= CNT_ZERO;
            valid_r      <= 1'b0;
            seen_first_r <= 1'b0;
        end else if (rise_s) begin
            ticks_r      <= count_r;
            valid_r      <= valid_r | seen_first_r;
            seen_first_r <= 1'b1;
        end else begin
            ticks_r      <= ticks_r;
            valid_r      <= valid_r;
            seen_first_r <= seen_first_r;
        end
    end

    assign rise        = rise_s;
    assign periodTicks = ticks_r;
    assign periodValid = valid_r;

endmodule

// File: rtl/powerline_event_sequencer.sv
// Power-line event sequencer: selects every Nth line trigger and emits a
// one-clock event strobe a programmable number of ticks later. Also reports
// the line period and counts triggers that arrive while a delay is pending.
module powerline_event_sequencer
    import powerline_event_sequencer_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH  = DEF_PERIOD_WIDTH,
    parameter int unsigned DELAY_WIDTH   = DEF_DELAY_WIDTH,
    parameter int unsigned DIVISOR_WIDTH = DEF_DIVISOR_WIDTH,
    parameter int unsigned OVERRUN_WIDTH = DEF_OVERRUN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trigger,
    input  logic                     powerlineTimeout,
    input  logic                     enable,
    input  logic [DELAY_WIDTH-1:0]   delayTicks,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic                     eventStrobe,
    output logic                     eventFromFake,
    output logic [PERIOD_WIDTH-1:0]  periodTicks,
    output logic                     periodValid,
    output logic [OVERRUN_WIDTH-1:0] overrunCount
);

    localparam logic [DELAY_WIDTH-1:0]   DLY_ZERO = {DELAY_WIDTH{1'b0}};
    localparam logic [DELAY_WIDTH-1:0]   DLY_ONE  = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIVISOR_WIDTH-1:0] DIV_ZERO = {DIVISOR_WIDTH{1'b0}};
    localparam logic [DIVISOR_WIDTH:0]   DIV_ONE  = {{DIVISOR_WIDTH{1'b0}}, 1'b1};
    localparam logic [OVERRUN_WIDTH-1:0] OVR_ZERO = {OVERRUN_WIDTH{1'b0}};
    localparam logic [OVERRUN_WIDTH-1:0] OVR_ONE  = {{(OVERRUN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OVERRUN_WIDTH-1:0] OVR_MAX  = {OVERRUN_WIDTH{1'b1}};

    pes_state_e               state_r, state_s;
    logic [DELAY_WIDTH-1:0]   dly_r, dly_s;
    logic                     strobe_r, strobe_s;
    logic                     fake_r, fake_s;
    logic                     ovr_inc_s;
    logic [OVERRUN_WIDTH-1:0] ovr_r;
    logic [DIVISOR_WIDTH-1:0] div_cnt_r;
    logic [DIVISOR_WIDTH:0]   div_next_s;
    logic [DIVISOR_WIDTH:0]   div_eff_s;
    logic                     hit_s;
    logic                     rise_s;
    logic                     accepted_s;

    powerline_period_meter #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_period (
        .clk         (clk),
        .rst_n       (rst_n),
        .trigger     (trigger),
        .rise        (rise_s),
        .periodTicks (periodTicks),
        .periodValid (periodValid)
    );

    // Divider hit: a divisor of 0 behaves as 1; one bit of headroom avoids wrap.
    always_comb begin
        div_next_s = {1'b0, div_cnt_r} + DIV_ONE;
        if (divisor == DIV_ZERO) begin
            div_eff_s = DIV_ONE;
        end else begin
            div_eff_s = {1'b0, divisor};
        end
        hit_s      = (div_next_s >= div_eff_s);
        accepted_s = rise_s & hit_s & enable;
    end

    // Divider counts every rise regardless of enable or FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= DIV_ZERO;
        end else if (rise_s && hit_s) begin
            div_cnt_r <= DIV_ZERO;
        end else if (rise_s) begin
            div_cnt_r <= div_next_s[DIVISOR_WIDTH-1:0];
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

    // Next-state and output decode of the delay FSM.
    always_comb begin
        state_s   = state_r;
        dly_s     = dly_r;
        strobe_s  = 1'b0;
        fake_s    = fake_r;
        ovr_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accepted_s) begin
                    dly_s   = delayTicks;
                    fake_s  = powerlineTimeout;
                    state_s = ST_DELAY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (!enable) begin
                    // Abort without a strobe; the captured source flag is kept.
                    state_s = ST_IDLE;
                end else if (dly_r == DLY_ZERO) begin
                    strobe_s = 1'b1;
                    if (accepted_s) begin
                        // Back-to-back: fire and immediately re-arm.
                        dly_s   = delayTicks;
                        fake_s  = powerlineTimeout;
                        state_s = ST_DELAY;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    dly_s     = dly_r - DLY_ONE;
                    ovr_inc_s = accepted_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                dly_s   = DLY_ZERO;
            end
        endcase
    end

    // FSM state, delay counter and registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            dly_r    <= DLY_ZERO;
            strobe_r <= 1'b0;
            fake_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            dly_r    <= dly_s;
            strobe_r <= strobe_s;
            fake_r   <= fake_s;
        end
    end

    // Saturating count of selected triggers lost to a pending delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_r <= OVR_ZERO;
        end else if (ovr_inc_s && (ovr_r != OVR_MAX)) begin
            ovr_r <= ovr_r + OVR_ONE;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    assign eventStrobe   = strobe_r;
    assign eventFromFake = fake_r;
    assign overrunCount  = ovr_r;

endmodule

// File: tb/tb_powerline_event_sequencer.sv
// Scoreboard bench for powerline_event_sequencer. Stimulus pushes the
// expected strobe cycle and source flag; a monitor checks every strobe.
module tb_powerline_event_sequencer;

    localparam int PW  = 10;
    localparam int DLW = 12;
    localparam int DVW = 8;
    localparam int OVW = 2;

    logic           clk;
    logic           rst_n;
    logic           trigger;
    logic           powerlineTimeout;
    logic           enable;
    logic [DLW-1:0] delayTicks;
    logic [DVW-1:0] divisor;
    logic           eventStrobe;
    logic           eventFromFake;
    logic [PW-1:0]  periodTicks;
    logic           periodValid;
    logic [OVW-1:0] overrunCount;

    typedef struct {
        int   cyc;
        logic fake;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_strobe = 1'b0;

    powerline_event_sequencer #(
        .PERIOD_WIDTH  (PW),
        .DELAY_WIDTH   (DLW),
        .DIVISOR_WIDTH (DVW),
        .OVERRUN_WIDTH (OVW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .trigger          (trigger),
        .powerlineTimeout (powerlineTimeout),
        .enable           (enable),
        .delayTicks       (delayTicks),
        .divisor          (divisor),
        .eventStrobe      (eventStrobe),
        .eventFromFake    (eventFromFake),
        .periodTicks      (periodTicks),
        .periodValid      (periodValid),
        .overrunCount     (overrunCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL missed_strobe: got none expected at cycle %0d", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (eventStrobe) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("strobe_cycle", cyc, e.cyc);
                    check("strobe_fake", {31'd0, eventFromFake}, {31'd0, e.fake});
                end
                if (prev_strobe) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL double_strobe: got 2 consecutive expected 1 (cycle %0d)", cyc);
                end
            end
        end
        prev_strobe = eventStrobe & rst_n;
    end

    // Called at a negedge; rise lands on the next posedge. Period = hi+lo.
    task automatic fire(input int hi, input int lo, input logic fake, input bit expect_strobe);
        int rc;
        exp_t e;
        powerlineTimeout = fake;
        trigger          = 1'b1;
        rc               = cyc + 1;
        if (expect_strobe) begin
            e.cyc  = rc + int'(delayTicks) + 1;
            e.fake = fake;
            exp_q.push_back(e);
        end
        repeat (hi) @(negedge clk);
        trigger = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        trigger          = 1'b0;
        powerlineTimeout = 1'b0;
        enable           = 1'b0;
        delayTicks       = 12'd0;
        divisor          = 8'd1;
        idle(3);
        check("rst_strobe", {31'd0, eventStrobe}, 32'd0);
        check("rst_fake", {31'd0, eventFromFake}, 32'd0);
        check("rst_period", {22'd0, periodTicks}, 32'd0);
        check("rst_valid", {31'd0, periodValid}, 32'd0);
        check("rst_overrun", {30'd0, overrunCount}, 32'd0);

        rst_n      = 1'b1;
        enable     = 1'b1;
        delayTicks = 12'd10;
        idle(2);

        // Basic line-synchronous strobes and period measurement
        fire(5, 45, 1'b0, 1'b1);
        check("valid_after_1st", {31'd0, periodValid}, 32'd0);
        fire(5, 45, 1'b0, 1'b1);
        check("period_2nd", {22'd0, periodTicks}, 32'd50);
        check("valid_after_2nd", {31'd0, periodValid}, 32'd1);
        fire(5, 45, 1'b0, 1'b1);
        fire(7, 43, 1'b0, 1'b1);
        check("period_4th", {22'd0, periodTicks}, 32'd50);

        // Divider: every third rise, then divisor 0 acts as 1
        divisor = 8'd3;
        for (int i = 1; i <= 9; i++) begin
            fire(5, 45, 1'b0, (i % 3) == 0);
        end
        divisor = 8'd0;
        for (int i = 0; i < 3; i++) begin
            fire(5, 45, 1'b0, 1'b1);
        end
        check("overrun_after_div", {30'd0, overrunCount}, 32'd0);

        // Expiry just before and exactly on the next accepted rise
        delayTicks = 12'd48;
        for (int i = 0; i < 3; i++) fire(5, 45, 1'b0, 1'b1);
        delayTicks = 12'd49;
        for (int i = 0; i < 3; i++) fire(5, 45, 1'b0, 1'b1);
        idle(60);
        check("overrun_on_expiry", {30'd0, overrunCount}, 32'd0);
        check("queue_after_expiry", exp_q.size(), 32'd0);

        // Delay longer than period: every other rise overruns, counter saturates
        delayTicks = 12'd60;
        for (int i = 1; i <= 8; i++) begin
            fire(5, 45, 1'b0, (i % 2) == 1);
            if (i == 4) check("overrun_2", {30'd0, overrunCount}, 32'd2);
        end
        idle(80);
        check("overrun_sat", {30'd0, overrunCount}, 32'd3);

        // Enable dropped mid-delay aborts; disabled rise ignored; re-enable works
        delayTicks       = 12'd20;
        powerlineTimeout = 1'b0;
        trigger          = 1'b1;
        idle(5);
        trigger = 1'b0;
        enable  = 1'b0;
        idle(3);
        enable = 1'b1;
        idle(42);
        fire(5, 45, 1'b0, 1'b1);
        enable = 1'b0;
        fire(5, 45, 1'b0, 1'b0);
        enable = 1'b1;
        fire(5, 45, 1'b0, 1'b1);
        idle(30);
        check("queue_after_enable", exp_q.size(), 32'd0);

        // Synthesized-trigger flag and period saturation
        delayTicks = 12'd10;
        fire(5, 45, 1'b1, 1'b1);
        check("fake_held_1", {31'd0, eventFromFake}, 32'd1);
        fire(5, 45, 1'b0, 1'b1);
        check("fake_held_0", {31'd0, eventFromFake}, 32'd0);
        idle(1100);
        fire(5, 45, 1'b0, 1'b1);
        check("period_saturated", {22'd0, periodTicks}, 32'd1023);
        fire(5, 45, 1'b0, 1'b1);
        check("period_after_sat", {22'd0, periodTicks}, 32'd50);

        // Asynchronous reset in the middle of a pending delay
        delayTicks       = 12'd30;
        powerlineTimeout = 1'b1;
        trigger          = 1'b1;
        idle(10);
        trigger = 1'b0;
        check("fake_before_rst", {31'd0, eventFromFake}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_strobe", {31'd0, eventStrobe}, 32'd0);
        check("arst_fake", {31'd0, eventFromFake}, 32'd0);
        check("arst_period", {22'd0, periodTicks}, 32'd0);
        check("arst_valid", {31'd0, periodValid}, 32'd0);
        check("arst_overrun", {30'd0, overrunCount}, 32'd0);
        idle(3);
        rst_n            = 1'b1;
        powerlineTimeout = 1'b0;
        idle(60);
        delayTicks = 12'd10;
        fire(5, 45, 1'b0, 1'b1);
        check("valid_after_rst_rise", {31'd0, periodValid}, 32'd0);
        idle(30);
        check("queue_final", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
